// File: rtl/dmem_refill.sv
// rtl/dmem_refill.sv - data-cache line-fill engine: one burst read per miss, BEATS bus words per line.
module dmem_refill #(
  parameter int LINE_W  = 512,
  parameter int BLK_W   = 58,
  parameter int BUS_W   = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BLK_W-1:0]  b_addr_d,
  input  logic              b_rd_d,
  output logic [LINE_W-1:0] b_rdata_d,
  output logic              b_dv_d,
  output logic              b_err_d,
  output logic              busy,
  output logic              m_req,
  output logic [63:0]       m_addr,
  input  logic              m_gnt,
  input  logic [BUS_W-1:0]  m_rdata,
  input  logic              m_rvalid,
  input  logic              m_rerr
);
  localparam int BEATS = LINE_W / BUS_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int OFF_W = 64 - BLK_W;

  typedef enum logic [1:0] {IDLE, REQ, BEAT, DONE} state_t;

  state_t            state_q, state_d;
  logic [BLK_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (b_rd_d) begin
          addr_d  = b_addr_d;
          line_d  = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (m_gnt) begin
          tmo_d   = '0;
          state_d = BEAT;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      BEAT: begin
        if (m_rvalid) begin
          for (int i = 0; i < BEATS; i++) begin
            if (cnt_q == CNT_W'(i)) line_d[i*BUS_W +: BUS_W] = m_rdata;
          end
          err_d = err_q | m_rerr;
          tmo_d = '0;
          // Counter holds at the last beat rather than wrapping.
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = DONE;
          else                             cnt_d   = cnt_q + 1'b1;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign b_rdata_d = line_q;
  assign b_dv_d    = (state_q == DONE);
  assign b_err_d   = (state_q == DONE) && err_q;
  assign busy      = (state_q != IDLE);
  assign m_req     = (state_q == REQ);
  assign m_addr    = {addr_q, {OFF_W{1'b0}}};
endmodule

// File: tb/tb_dmem_refill.sv
// tb/tb_dmem_refill.sv - directed self-checking bench for dmem_refill.
module tb_dmem_refill;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [57:0]  b_addr_d = '0;
  logic         b_rd_d = 1'b0;
  logic [511:0] b_rdata_d;
  logic         b_dv_d, b_err_d, busy, m_req;
  logic [63:0]  m_addr;
  logic         m_gnt = 1'b0;
  logic [63:0]  m_rdata = '0;
  logic         m_rvalid = 1'b0;
  logic         m_rerr = 1'b0;

  int total = 0;
  int bad = 0;

  dmem_refill dut (
    .clk(clk), .rst_n(rst_n), .b_addr_d(b_addr_d), .b_rd_d(b_rd_d),
    .b_rdata_d(b_rdata_d), .b_dv_d(b_dv_d), .b_err_d(b_err_d), .busy(busy),
    .m_req(m_req), .m_addr(m_addr), .m_gnt(m_gnt), .m_rdata(m_rdata),
    .m_rvalid(m_rvalid), .m_rerr(m_rerr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] exp_line(input int nbeats, input logic [63:0] seed);
    logic [511:0] l;
    l = '0;
    for (int i = 0; i < nbeats; i++) l[i*64 +: 64] = seed + 64'(i);
    return l;
  endfunction

  // Plays the cache and memory for one fill; cycle 0 is the cycle b_rd_d is first seen in IDLE.
  task automatic do_fill(input logic [57:0] addr, input int gdly, input int gap, input int err_beat,
                         input int nbeats, input logic [63:0] seed, input bit tog_addr,
                         input int rst_beat, output int dv_cyc, output int req_cyc,
                         output logic err_o, output logic [511:0] line_o, output logic [63:0] maddr_o);
    int w, gc, sent;
    dv_cyc = -1; req_cyc = 0; err_o = 1'b0; line_o = '0; maddr_o = '0;
    w = 0; gc = 0; sent = 0;
    b_rd_d = 1'b1;
    b_addr_d = addr;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      m_gnt = 1'b0; m_rvalid = 1'b0; m_rerr = 1'b0; m_rdata = '0;
      if (b_dv_d) begin
        dv_cyc = cyc;
        err_o = b_err_d;
        line_o = b_rdata_d;
        b_rd_d = 1'b0;
        return;
      end
      if (m_req) begin
        req_cyc++;
        maddr_o = m_addr;
        if (w == gdly) m_gnt = 1'b1;
        w++;
      end else if (busy) begin
        if (tog_addr) b_addr_d = ~b_addr_d;
        if (sent == rst_beat) begin
          rst_n = 1'b0;
          b_rd_d = 1'b0;
          return;
        end
        if (sent < nbeats) begin
          if (gc == 0) begin
            m_rvalid = 1'b1;
            m_rdata = seed + 64'(sent);
            m_rerr = (sent == err_beat);
            sent++;
            gc = gap;
          end else begin
            gc--;
          end
        end
      end
      step();
    end
  endtask

  int dv_cyc, req_cyc;
  logic err_o;
  logic [511:0] line_o, held;
  logic [63:0] maddr_o;

  initial begin
    #2;
    check("rst_busy", busy, 0);
    check("rst_dv", b_dv_d, 0);
    check("rst_err", b_err_d, 0);
    check("rst_mreq", m_req, 0);
    check("rst_maddr", m_addr, 0);
    check("rst_rdata", b_rdata_d, 0);
    step();
    rst_n = 1'b1;
    step();

    // Basic fill
    do_fill(58'h1, 0, 0, -1, 8, 64'h0, 0, -1, dv_cyc, req_cyc, err_o, line_o, maddr_o);
    check("basic_maddr", maddr_o, 64'h40);
    check("basic_req", req_cyc, 1);
    check("basic_lat", dv_cyc, 10);
    check("basic_err", err_o, 0);
    check("basic_line", line_o, exp_line(8, 64'h0));
    step();
    check("basic_dv_drop", b_dv_d, 0);
    check("basic_idle", busy, 0);
    step(); step();
    check("basic_hold", b_rdata_d, exp_line(8, 64'h0));

    // Backpressure: late grant, one-cycle gaps between beats
    do_fill(58'h2AB, 5, 1, -1, 8, 64'h1000, 0, -1, dv_cyc, req_cyc, err_o, line_o, maddr_o);
    check("bp_maddr", maddr_o, 64'hAAC0);
    check("bp_req", req_cyc, 6);
    check("bp_lat", dv_cyc, 22);
    check("bp_err", err_o, 0);
    check("bp_line", line_o, exp_line(8, 64'h1000));
    step();
    check("bp_single", b_dv_d, 0);

    // Error on beat 3
    do_fill(58'h7, 0, 0, 3, 8, 64'hA5A5_0000, 0, -1, dv_cyc, req_cyc, err_o, line_o, maddr_o);
    check("err_lat", dv_cyc, 10);
    check("err_flag", err_o, 1);
    check("err_line", line_o, exp_line(8, 64'hA5A5_0000));
    step();
    check("err_drop", b_err_d, 0);

    // Spurious memory traffic while idle
    held = b_rdata_d;
    for (int i = 0; i < 4; i++) begin
      m_rvalid = 1'b1; m_rerr = 1'b1; m_gnt = 1'b1; m_rdata = 64'hDEAD;
      step();
      check("spur_busy", busy, 0);
      check("spur_dv", b_dv_d, 0);
    end
    m_rvalid = 1'b0; m_rerr = 1'b0; m_gnt = 1'b0; m_rdata = '0;
    check("spur_hold", b_rdata_d, held);

    // Fill with b_addr_d toggling after acceptance
    do_fill(58'h155, 1, 0, -1, 8, 64'h3300, 1, -1, dv_cyc, req_cyc, err_o, line_o, maddr_o);
    check("tog_maddr", maddr_o, 64'h5540);
    check("tog_maddr_end", m_addr, 64'h5540);
    check("tog_err", err_o, 0);
    check("tog_line", line_o, exp_line(8, 64'h3300));
    step();

    // Timeout after two beats
    do_fill(58'h9, 0, 0, -1, 2, 64'h77, 0, -1, dv_cyc, req_cyc, err_o, line_o, maddr_o);
    check("tmo_lat", dv_cyc, 259);
    check("tmo_err", err_o, 1);
    check("tmo_line", line_o, exp_line(2, 64'h77));
    step();
    check("tmo_idle", busy, 0);
    check("tmo_mreq", m_req, 0);

    // Reset during beat 4
    do_fill(58'h3, 0, 0, -1, 8, 64'h500, 0, 4, dv_cyc, req_cyc, err_o, line_o, maddr_o);
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dv", b_dv_d, 0);
    check("mid_rst_mreq", m_req, 0);
    check("mid_rst_maddr", m_addr, 0);
    check("mid_rst_rdata", b_rdata_d, 0);
    m_rvalid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_dv", b_dv_d, 0);
    do_fill(58'h4, 0, 0, -1, 8, 64'h900, 0, -1, dv_cyc, req_cyc, err_o, line_o, maddr_o);
    check("post_rst_lat", dv_cyc, 10);
    check("post_rst_maddr", maddr_o, 64'h100);
    check("post_rst_line", line_o, exp_line(8, 64'h900));
    check("post_rst_err", err_o, 0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
